// File: rtl/pe_pkg.sv
// Shared types and constants for the PE-column opsum accumulator.
package pe_pkg;

    localparam int unsigned PE_PSUM_W = 8;
    localparam int unsigned PE_ACC_W  = 16;
    localparam int unsigned PE_OUT_W  = 8;

    typedef logic signed [PE_PSUM_W-1:0] psum_t;
    typedef logic signed [PE_ACC_W-1:0]  acc_t;
    typedef logic signed [PE_OUT_W-1:0]  ofmap_t;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DRAIN
    } state_t;

    // Saturation bounds at the default widths
    localparam acc_t   ACC_MAX = {1'b0, {(PE_ACC_W-1){1'b1}}};
    localparam acc_t   ACC_MIN = {1'b1, {(PE_ACC_W-1){1'b0}}};
    localparam ofmap_t OUT_MAX = {1'b0, {(PE_OUT_W-1){1'b1}}};
    localparam ofmap_t OUT_MIN = {1'b1, {(PE_OUT_W-1){1'b0}}};

endpackage

// File: rtl/opsum_accumulator_sat_narrow.sv
// sat_narrow: combinational signed saturating reduction from IN_W to OUT_W bits.
module sat_narrow #(
    parameter int unsigned IN_W  = 17,
    parameter int unsigned OUT_W = 16
) (
    input  logic signed [IN_W-1:0]  i_din,
    output logic signed [OUT_W-1:0] o_dout
);

    // Output-range bounds expressed at the input width so the compare is exact
    localparam logic signed [IN_W-1:0] MAXV = {{(IN_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [IN_W-1:0] MINV = {{(IN_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    always_comb begin
        o_dout = i_din[OUT_W-1:0];
        if (i_din > MAXV) begin
            o_dout = MAXV[OUT_W-1:0];
        end else if (i_din < MINV) begin
            o_dout = MINV[OUT_W-1:0];
        end
    end

endmodule

// File: rtl/opsum_accumulator.sv
// Multi-pass signed psum accumulator with saturated drain to the GLB write path.
// Optional build macro OPSUM_ACC_RELU_EN clamps negative drained values to zero.
module opsum_accumulator
    import pe_pkg::*;
#(
    parameter int unsigned PSUM_DATA_SIZE = 8,
    parameter int unsigned ACC_DATA_SIZE  = 16,
    parameter int unsigned OUT_DATA_SIZE  = 8,
    parameter int unsigned ACC_DEPTH      = 24,
    parameter int unsigned CONFIG_F_BIT   = 8,
    parameter int unsigned CONFIG_N_BIT   = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             set_info,
    input  logic [CONFIG_F_BIT-1:0]          config_F,
    input  logic [CONFIG_N_BIT-1:0]          config_N,
    input  logic signed [PSUM_DATA_SIZE-1:0] opsum,
    input  logic                             opsum_enable,
    output logic                             opsum_ready,
    output logic signed [OUT_DATA_SIZE-1:0]  ofmap,
    output logic                             ofmap_enable,
    input  logic                             ofmap_ready,
    output logic                             busy,
    output logic                             done
);

    localparam int unsigned IDX_W = (ACC_DEPTH > 1) ? $clog2(ACC_DEPTH) : 1;

    state_t                          r_state;
    logic [IDX_W-1:0]                r_idx;
    logic [IDX_W-1:0]                r_f_last;
    logic [CONFIG_N_BIT-1:0]         r_pass;
    logic [CONFIG_N_BIT-1:0]         r_n_last;
    logic                            r_ofmap_enable;
    logic                            r_done;
    logic signed [ACC_DATA_SIZE-1:0] r_acc [ACC_DEPTH];

    logic [IDX_W-1:0]                w_f_last;
    logic [CONFIG_N_BIT-1:0]         w_n_last;
    logic                            w_accept;
    logic                            w_last_idx;
    logic                            w_last_pass;
    logic signed [ACC_DATA_SIZE-1:0] w_opsum_ext;
    logic signed [ACC_DATA_SIZE-1:0] w_cur;
    logic signed [ACC_DATA_SIZE:0]   w_sum;
    logic signed [ACC_DATA_SIZE-1:0] w_sum_sat;
    logic signed [ACC_DATA_SIZE-1:0] w_wr;
    logic signed [ACC_DATA_SIZE-1:0] w_pre_out;
    logic signed [OUT_DATA_SIZE-1:0] w_ofmap;

    // Stored as last-index / last-pass so the hot compares need no subtract
    always_comb begin
        if (config_F == '0) begin
            w_f_last = '0;
        end else if (config_F > CONFIG_F_BIT'(ACC_DEPTH)) begin
            w_f_last = IDX_W'(ACC_DEPTH - 1);
        end else begin
            w_f_last = IDX_W'(config_F - 1'b1);
        end
        w_n_last = (config_N == '0) ? '0 : config_N - 1'b1;
    end

    assign w_accept    = (r_state == ACCUM) && opsum_enable;
    assign w_last_idx  = (r_idx == r_f_last);
    assign w_last_pass = (r_pass == r_n_last);

    assign w_opsum_ext = {{(ACC_DATA_SIZE-PSUM_DATA_SIZE){opsum[PSUM_DATA_SIZE-1]}}, opsum};
    assign w_cur       = r_acc[r_idx];
    assign w_sum       = {w_cur[ACC_DATA_SIZE-1], w_cur} +
                         {w_opsum_ext[ACC_DATA_SIZE-1], w_opsum_ext};

    sat_narrow #(
        .IN_W  (ACC_DATA_SIZE + 1),
        .OUT_W (ACC_DATA_SIZE)
    ) u_sat_acc (
        .i_din  (w_sum),
        .o_dout (w_sum_sat)
    );

    assign w_wr = (r_pass == '0) ? w_opsum_ext : w_sum_sat;

    // Buffer has no reset: pass 0 always overwrites every live entry
    always_ff @(posedge clk) begin
        if (rst && w_accept) begin
            r_acc[r_idx] <= w_wr;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state        <= IDLE;
            r_idx          <= '0;
            r_pass         <= '0;
            r_ofmap_enable <= 1'b0;
            r_done         <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (set_info) begin
                        r_f_last <= w_f_last;
                        r_n_last <= w_n_last;
                        r_idx    <= '0;
                        r_pass   <= '0;
                        r_state  <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (opsum_enable) begin
                        if (w_last_idx) begin
                            r_idx  <= '0;
                            r_pass <= r_pass + 1'b1;
                            if (w_last_pass) begin
                                r_state        <= DRAIN;
                                r_ofmap_enable <= 1'b1;
                            end
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (ofmap_ready) begin
                        if (w_last_idx) begin
                            r_idx          <= '0;
                            r_ofmap_enable <= 1'b0;
                            r_done         <= 1'b1;
                            r_state        <= IDLE;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef OPSUM_ACC_RELU_EN
    assign w_pre_out = w_cur[ACC_DATA_SIZE-1] ? '0 : w_cur;
`else
    assign w_pre_out = w_cur;
`endif

    sat_narrow #(
        .IN_W  (ACC_DATA_SIZE),
        .OUT_W (OUT_DATA_SIZE)
    ) u_sat_out (
        .i_din  (w_pre_out),
        .o_dout (w_ofmap)
    );

    assign ofmap        = w_ofmap;
    assign ofmap_enable = r_ofmap_enable;
    assign opsum_ready  = (r_state == ACCUM);
    assign busy         = (r_state != IDLE);
    assign done         = r_done;

endmodule

// File: tb/tb_opsum_accumulator.sv
// Scoreboard bench for opsum_accumulator: directed jobs, monitor pops expected ofmap values.
module tb_opsum_accumulator;

    logic              clk;
    logic              rst;
    logic              set_info;
    logic [7:0]        config_F;
    logic [3:0]        config_N;
    logic signed [7:0] opsum;
    logic              opsum_enable;
    logic              opsum_ready;
    logic signed [7:0] ofmap;
    logic              ofmap_enable;
    logic              ofmap_ready;
    logic              busy;
    logic              done;

    int total = 0;
    int bad   = 0;
    int done_cnt = 0;
    int jobs_expected = 0;
    int sb[$];
    logic       hold_v = 1'b0;
    logic [7:0] held;

    opsum_accumulator #(
        .PSUM_DATA_SIZE (8),
        .ACC_DATA_SIZE  (16),
        .OUT_DATA_SIZE  (8),
        .ACC_DEPTH      (24),
        .CONFIG_F_BIT   (8),
        .CONFIG_N_BIT   (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .set_info     (set_info),
        .config_F     (config_F),
        .config_N     (config_N),
        .opsum        (opsum),
        .opsum_enable (opsum_enable),
        .opsum_ready  (opsum_ready),
        .ofmap        (ofmap),
        .ofmap_enable (ofmap_enable),
        .ofmap_ready  (ofmap_ready),
        .busy         (busy),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Expected drained value from a hand-computed accumulator sum
    function automatic int exp_out(input int v);
        int r;
        r = v;
`ifdef OPSUM_ACC_RELU_EN
        if (r < 0) r = 0;
`endif
        if (r > 127) r = 127;
        if (r < -128) r = -128;
        return r;
    endfunction

    always @(negedge clk) begin
        if (rst && done) done_cnt++;
        if (rst && ofmap_enable) begin
            if (hold_v) check("stall_hold", int'(ofmap), int'($signed(held)));
            if (ofmap_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_ofmap", int'(ofmap), 999);
                end else begin
                    check("ofmap", int'(ofmap), sb.pop_front());
                end
                hold_v = 1'b0;
            end else begin
                held   = ofmap;
                hold_v = 1'b1;
            end
        end else begin
            hold_v = 1'b0;
        end
    end

    task automatic start_job(input int f, input int n);
        set_info = 1'b1;
        config_F = 8'(f);
        config_N = 4'(n);
        @(posedge clk); #1;
        set_info = 1'b0;
    endtask

    task automatic send(input int v, input int gap);
        int k;
        opsum        = 8'(v);
        opsum_enable = 1'b1;
        k = 0;
        while (!opsum_ready && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        check("accept_ready", int'(opsum_ready), 1);
        @(posedge clk); #1;
        opsum_enable = 1'b0;
        repeat (gap) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_done(input string name);
        int k;
        jobs_expected++;
        k = 0;
        while (done_cnt < jobs_expected && k < 400) begin
            @(negedge clk);
            k++;
        end
        check({name, "_done"}, done_cnt, jobs_expected);
        @(negedge clk);
        check({name, "_done_pulse"}, int'(done), 0);
        check({name, "_busy_idle"}, int'(busy), 0);
        check({name, "_sb_empty"}, sb.size(), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; set_info = 1'b0; config_F = '0; config_N = '0;
        opsum = '0; opsum_enable = 1'b0; ofmap_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_opsum_ready", int'(opsum_ready), 0);
        check("rst_ofmap_enable", int'(ofmap_enable), 0);
        check("rst_done", int'(done), 0);
        check("rst_busy", int'(busy), 0);
        rst = 1'b1;
        @(posedge clk); #1;

        // Single pass, back-to-back
        start_job(4, 1);
        check("busy_accum", int'(busy), 1);
        for (int i = 1; i <= 4; i++) sb.push_back(exp_out(i));
        for (int i = 1; i <= 4; i++) send(i, 0);
        wait_done("f4n1");

        // Three passes of {10,-5,7}
        start_job(3, 3);
        sb.push_back(exp_out(30)); sb.push_back(exp_out(-15)); sb.push_back(exp_out(21));
        for (int p = 0; p < 3; p++) begin
            send(10, 0); send(-5, 0); send(7, 0);
        end
        wait_done("f3n3");

        // Output saturation: sums 200 / -200
        start_job(2, 2);
        sb.push_back(exp_out(200)); sb.push_back(exp_out(-200));
        for (int p = 0; p < 2; p++) begin
            send(100, 0); send(-100, 0);
        end
        wait_done("sat");

        // Input bubbles and a 3-cycle drain stall
        start_job(4, 1);
        for (int i = 5; i <= 8; i++) sb.push_back(exp_out(i));
        for (int i = 5; i <= 8; i++) send(i, (i == 8) ? 0 : 1);
        check("drain_entry_valid", int'(ofmap_enable), 1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        ofmap_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        ofmap_ready = 1'b1;
        wait_done("stall");

        // config_F=0 acts as 1, two passes -> 5+6
        start_job(0, 2);
        sb.push_back(exp_out(11));
        send(5, 0); send(6, 0);
        wait_done("f0");

        // config_F=40 clamps to 24, config_N=0 is one pass
        start_job(40, 0);
        for (int i = 0; i < 24; i++) sb.push_back(exp_out(i - 12));
        for (int i = 0; i < 24; i++) send(i - 12, 0);
        wait_done("f40n0");

        // set_info during ACCUM must not alter the running job
        start_job(2, 1);
        sb.push_back(exp_out(3)); sb.push_back(exp_out(4));
        send(3, 0);
        set_info = 1'b1; config_F = 8'd5; config_N = 4'd3;
        @(posedge clk); #1;
        set_info = 1'b0;
        send(4, 0);
        wait_done("seti_ignored");

        // Reset mid-ACCUM abandons the job; next job sees no stale sums
        start_job(2, 2);
        send(50, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        check("midrst_opsum_ready", int'(opsum_ready), 0);
        check("midrst_ofmap_enable", int'(ofmap_enable), 0);
        check("midrst_done", int'(done), 0);
        check("midrst_busy", int'(busy), 0);
        start_job(2, 1);
        sb.push_back(exp_out(9)); sb.push_back(exp_out(9));
        send(9, 0); send(9, 0);
        wait_done("post_rst");

        check("final_sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
